// File: rtl/the_pkg.sv
// Opcode and R-type function-code encodings shared by the instruction encoder and its users.
package the_pkg;

    typedef enum logic [5:0] {
        Rtype = 6'h00,
        JUMP  = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ANDI  = 6'h0C,
        ORI   = 6'h0D,
        XORI  = 6'h0E,
        LUI   = 6'h0F,
        LW    = 6'h23,
        SW    = 6'h2B,
        RET   = 6'h3F
    } op_code;

    typedef enum logic [5:0] {
        SLL_f = 6'h00,
        SLA_f = 6'h01,
        SRL_f = 6'h02,
        SRA_f = 6'h03,
        ADD_f = 6'h20,
        SUB_f = 6'h22,
        AND_f = 6'h24,
        OR_f  = 6'h25,
        XOR_f = 6'h26
    } func_code;

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-field stream into the encoder plus its instruction-memory write port.
interface instr_encoder_if #(parameter int unsigned AW = 8);

    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    the_pkg::op_code    op;
    the_pkg::func_code  func;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shamt;
    logic [15:0]        imm;
    logic [25:0]        target;
    logic               im_we;
    logic [AW-1:0]      im_addr;
    logic [31:0]        im_wdata;

    modport master (
        output in_valid, in_last, op, func, rs, rt, rd, shamt, imm, target,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_last, op, func, rs, rt, rd, shamt, imm, target,
        output in_ready, im_we, im_addr, im_wdata
    );

endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic instruction fields into 32-bit words and writes them sequentially into
// instruction memory. Optional legality filter enabled by defining INSTR_ENC_LEGAL_CHECK_EN.
module instr_encoder
    import the_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [AW-1:0]   i_base_addr,
    instr_encoder_if.slave  bus,
    output logic            o_busy,
    output logic            o_done,
    output logic [AW:0]     o_count,
    output logic [1:0]      o_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

    localparam logic [AW-1:0] TOP_ADDR = '1;

    state_t         r_state, w_state_nxt;
    logic [AW-1:0]  r_ptr, w_ptr_nxt;
    logic [AW:0]    r_count, w_count_nxt;
    logic [1:0]     r_err, w_err_nxt;
    logic           r_ready, w_ready_nxt;
    logic           r_we, w_we_nxt;
    logic [AW-1:0]  r_addr, w_addr_nxt;
    logic [31:0]    r_wdata, w_wdata_nxt;
    logic           r_last_pend, w_last_pend_nxt;
    logic           r_done, w_done_nxt;
    logic           r_busy, w_busy_nxt;

    logic           w_accept;
    logic           w_legal;
    logic           w_write;
    logic           w_ovf;
    logic [31:0]    w_word;

    assign w_accept = bus.in_valid && r_ready;
    assign w_write  = w_accept && w_legal;
    assign w_ovf    = w_write && (r_ptr == TOP_ADDR) && !bus.in_last;

    // Word layout selected by opcode format
    always_comb begin
        w_word = {bus.op, bus.rs, bus.rt, bus.imm};
        case (bus.op)
            Rtype:     w_word = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.func};
            JUMP, JAL: w_word = {bus.op, bus.target};
            RET:       w_word = {bus.op, bus.rs, 21'b0};
            default:   w_word = {bus.op, bus.rs, bus.rt, bus.imm};
        endcase
    end

`ifdef INSTR_ENC_LEGAL_CHECK_EN
    always_comb begin
        w_legal = 1'b0;
        case (bus.op)
            Rtype: begin
                case (bus.func)
                    ADD_f, SUB_f, AND_f, OR_f, XOR_f,
                    SLL_f, SRL_f, SLA_f, SRA_f: w_legal = 1'b1;
                    default:                    w_legal = 1'b0;
                endcase
            end
            JUMP, JAL, BEQ, BNE, ADDI, ANDI, ORI, XORI,
            LUI, LW, SW, RET: w_legal = 1'b1;
            default:          w_legal = 1'b0;
        endcase
    end
`else
    assign w_legal = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_FULL: if (i_start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_accept && bus.in_last) w_state_nxt = S_IDLE;
                else if (w_ovf)              w_state_nxt = S_FULL;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for the datapath and all registered outputs
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_count_nxt     = r_count;
        w_err_nxt       = r_err;
        w_we_nxt        = 1'b0;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_last_pend_nxt = 1'b0;
        w_done_nxt      = r_we && r_last_pend;
        if ((r_state != S_LOAD) && i_start) begin
            w_ptr_nxt   = i_base_addr;
            w_count_nxt = '0;
            w_err_nxt   = 2'b00;
        end
        if (w_write) begin
            w_we_nxt        = 1'b1;
            w_addr_nxt      = r_ptr;
            w_wdata_nxt     = w_word;
            w_last_pend_nxt = bus.in_last;
            w_count_nxt     = r_count + (AW+1)'(1);
            // Pointer saturates at the top address rather than wrapping
            if (r_ptr != TOP_ADDR) w_ptr_nxt = r_ptr + AW'(1);
            if (w_ovf)             w_err_nxt[1] = 1'b1;
        end else if (w_accept) begin
            w_err_nxt[0] = 1'b1;
            if (bus.in_last) w_done_nxt = 1'b1;
        end
        w_ready_nxt = (w_state_nxt == S_LOAD);
        w_busy_nxt  = (w_state_nxt == S_LOAD) || w_we_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_err       <= 2'b00;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_last_pend <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_count     <= w_count_nxt;
            r_err       <= w_err_nxt;
            r_ready     <= w_ready_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_last_pend <= w_last_pend_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.im_we    = r_we;
    assign bus.im_addr  = r_addr;
    assign bus.im_wdata = r_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_count      = r_count;
    assign o_err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus queues expected memory writes, a monitor checks them.
module tb_instr_encoder;
    import the_pkg::*;

    localparam int unsigned AW = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic           busy;
    logic           done;
    logic [AW:0]    count;
    logic [1:0]     err;

    instr_encoder_if #(.AW(AW)) bus ();

    instr_encoder #(.AW(AW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .bus         (bus),
        .o_busy      (busy),
        .o_done      (done),
        .o_count     (count),
        .o_err       (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [AW+31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && bus.im_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {32'd0, bus.im_wdata}, 64'hDEAD_0000);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                chk("im_addr",  64'(bus.im_addr),  64'(e[AW+31:32]));
                chk("im_wdata", 64'(bus.im_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input op_code op, input func_code f, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last, input logic exp_we,
                        input logic [AW-1:0] exp_addr, input logic [31:0] exp_data);
        int w;
        bus.op = op; bus.func = f; bus.rs = rs; bus.rt = rt; bus.rd = rd;
        bus.shamt = sh; bus.imm = imm; bus.target = tgt; bus.in_last = last;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) chk("send_timeout", 64'(w), 64'd0);
        if (exp_we) exp_q.push_back({exp_addr, exp_data});
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called right after the last word is accepted
    task automatic finish_check(input string name, input int exp_count);
        tick();
        chk({name, "_done"},  64'(done), 64'd1);
        chk({name, "_count"}, 64'(count), 64'(exp_count));
        chk({name, "_ready"}, 64'(bus.in_ready), 64'd0);
        chk({name, "_busy"},  64'(busy), 64'd0);
        tick();
        chk({name, "_done_off"}, 64'(done), 64'd0);
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_ready"}, 64'(bus.in_ready), 64'd0);
        chk({name, "_we"},    64'(bus.im_we), 64'd0);
        chk({name, "_addr"},  64'(bus.im_addr), 64'd0);
        chk({name, "_wdata"}, 64'(bus.im_wdata), 64'd0);
        chk({name, "_busy"},  64'(busy), 64'd0);
        chk({name, "_done"},  64'(done), 64'd0);
        chk({name, "_count"}, 64'(count), 64'd0);
        chk({name, "_err"},   64'(err), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.op = Rtype; bus.func = ADD_f;
        bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.shamt = '0; bus.imm = '0; bus.target = '0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 64'(bus.in_ready), 64'd0);

        // Single ADDI with in_last
        pulse_start(8'h10);
        chk("load_ready", 64'(bus.in_ready), 64'd1);
        chk("load_busy",  64'(busy), 64'd1);
        send(ADDI, ADD_f, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b1, 1'b1, 8'h10, 32'h2022_0005);
        chk("t1_we_now", 64'(bus.im_we), 64'd1);
        finish_check("t1", 1);

        // Back-to-back R / J / RET
        pulse_start(8'h20);
        send(Rtype, ADD_f, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'd0, 1'b0, 1'b1, 8'h20, 32'h0064_2820);
        send(JAL, ADD_f, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b0, 1'b1, 8'h21, 32'h0C00_0040);
        send(RET, ADD_f, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0, 1'b1, 1'b1, 8'h22, 32'hFFE0_0000);
        finish_check("t2", 3);

        // in_valid 1-0-1 with a gap cycle
        pulse_start(8'h30);
        send(ORI, ADD_f, 5'd7, 5'd8, 5'd0, 5'd0, 16'hBEEF, 26'd0, 1'b0, 1'b1, 8'h30, 32'h34E8_BEEF);
        tick();
        chk("gap_we", 64'(bus.im_we), 64'd0);
        send(LW, ADD_f, 5'd1, 5'd9, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b1, 1'b1, 8'h31, 32'h8C29_0004);
        finish_check("t3", 2);

        // Overflow at the top address
        pulse_start(8'hFE);
        send(ADDI, ADD_f, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'd0, 1'b0, 1'b1, 8'hFE, 32'h2001_0001);
        send(ADDI, ADD_f, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0002, 26'd0, 1'b0, 1'b1, 8'hFF, 32'h2002_0002);
        chk("ovf_ready", 64'(bus.in_ready), 64'd0);
        chk("ovf_err",   64'(err), 64'd2);
        chk("ovf_count", 64'(count), 64'd2);
        bus.in_valid = 1'b1;
        repeat (3) tick();
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        chk("full_done",  64'(done), 64'd0);
        bus.in_valid = 1'b0;
        pulse_start(8'h40);
        chk("restart_err",   64'(err), 64'd0);
        chk("restart_ready", 64'(bus.in_ready), 64'd1);
        chk("restart_count", 64'(count), 64'd0);
        send(XORI, ADD_f, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b1, 1'b1, 8'h40, 32'h3843_00FF);
        finish_check("t4", 1);

        // Last word exactly at the top address completes without error
        pulse_start(8'hFF);
        send(ANDI, ADD_f, 5'd4, 5'd5, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b1, 1'b1, 8'hFF, 32'h3085_1234);
        finish_check("t5", 1);
        chk("t5_err", 64'(err), 64'd0);

        // start while loading is ignored
        pulse_start(8'h50);
        send(BEQ, ADD_f, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0, 1'b1, 8'h50, 32'h1022_FFFF);
        pulse_start(8'h60);
        chk("ign_start_count", 64'(count), 64'd1);
        send(JUMP, ADD_f, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 1'b1, 1'b1, 8'h51, 32'h0BFF_FFFF);
        finish_check("t6", 2);

        // Undefined R-type function code
        pulse_start(8'h70);
`ifdef INSTR_ENC_LEGAL_CHECK_EN
        send(Rtype, func_code'(6'h3F), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 1'b0, 1'b0, 8'h70, 32'h0);
        tick();
        chk("illegal_err",   64'(err), 64'd1);
        chk("illegal_count", 64'(count), 64'd0);
        send(Rtype, SUB_f, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 1'b1, 1'b1, 8'h70, 32'h0022_1822);
        finish_check("t7", 1);
        chk("t7_err", 64'(err), 64'd1);
`else
        send(Rtype, func_code'(6'h3F), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 1'b0, 1'b1, 8'h70, 32'h0022_183F);
        send(Rtype, SUB_f, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'd0, 1'b1, 1'b1, 8'h71, 32'h0022_1822);
        finish_check("t7", 2);
        chk("t7_err", 64'(err), 64'd0);
`endif

        // Reset right after an accept discards the pending write
        pulse_start(8'h80);
        bus.op = ADDI; bus.rs = 5'd1; bus.rt = 5'd1; bus.imm = 16'h0001; bus.in_last = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        chk("post_rst_ready", 64'(bus.in_ready), 64'd0);
        chk("post_rst_count", 64'(count), 64'd0);

        repeat (2) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
